// File: rtl/gpu_scanout.sv
// gpu_scanout: 640x480 VGA timing generator that scans a 256x256 RGB444 image out of a pixel ROM.
// Latency: colour, syncs and frame_start are registered one pixel (one pix_ce) after the counters; ROM address/enable are combinational.
// Backpressure: none; the pixel clock free-runs, and the ROM must return data in the same clk.
//
// Build option: define GPU_SCANOUT_TESTPAT_EN to add the test_en input and its generated test pattern.
//
// Ports:
//   clk, rst_n           - system clock, asynchronous active-low reset
//   test_en              - (GPU_SCANOUT_TESTPAT_EN only) replace the image window with a generated pattern
//   rom_addr, rom_rd_en  - pixel ROM address {row, col} and read enable (window only)
//   rom_data             - RGB444 pixel from the ROM, valid in the same cycle
//   vga_r/g/b            - registered colour, 4 bits per channel
//   vga_hs, vga_vs       - registered syncs, active low
//   frame_start          - one-clk pulse on the pixel that presents hcnt=0, vcnt=0
module gpu_scanout #(
  parameter int          CLK_DIV  = 4,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef GPU_SCANOUT_TESTPAT_EN
  input  logic        test_en,
`endif
  output logic [15:0] rom_addr,
  output logic        rom_rd_en,
  input  logic [11:0] rom_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  // 640x480 timing: active / front porch / sync / back porch
  localparam logic [9:0] H_ACT     = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_ACT     = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;
  localparam logic [9:0] V_LAST    = 10'd524;

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  // Window bounds held at 11 bits so IMG_X0+255 cannot wrap against the 10-bit counters
  localparam logic [10:0] X_LO = 11'(IMG_X0);
  localparam logic [10:0] X_HI = 11'(IMG_X0 + 255);
  localparam logic [10:0] Y_LO = 11'(IMG_Y0);
  localparam logic [10:0] Y_HI = 11'(IMG_Y0 + 255);
  localparam logic [7:0]  X0_8 = 8'(IMG_X0);
  localparam logic [7:0]  Y0_8 = 8'(IMG_Y0);

  logic [2:0]  div_q, div_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;

  logic        pix_ce;
  logic        active;
  logic        in_win;
  logic        use_rom;
  logic [7:0]  col, row;
  logic [11:0] win_color;

  assign pix_ce = (div_q == DIV_LAST);

  // Pixel divider and raster counters
  always_comb begin
    div_d  = div_q + 3'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce) begin
      div_d = 3'd0;
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Window decode; the 8-bit subtraction equals the low byte of the full offset
  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign in_win = active
                  && ({1'b0, hcnt_q} >= X_LO) && ({1'b0, hcnt_q} <= X_HI)
                  && ({1'b0, vcnt_q} >= Y_LO) && ({1'b0, vcnt_q} <= Y_HI);
  assign col    = hcnt_q[7:0] - X0_8;
  assign row    = vcnt_q[7:0] - Y0_8;

  assign rom_addr = in_win ? {row, col} : 16'h0000;

`ifdef GPU_SCANOUT_TESTPAT_EN
  // Test pattern takes over the window and silences the ROM; the address still tracks the raster
  assign use_rom   = in_win && !test_en;
  assign win_color = test_en ? {hcnt_q[7:4], vcnt_q[7:4], hcnt_q[7:4] ^ vcnt_q[7:4]} : rom_data;
`else
  assign use_rom   = in_win;
  assign win_color = rom_data;
`endif

  assign rom_rd_en = use_rom;

  // Output stage: colour and syncs advance together on pix_ce, hold otherwise
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    if (pix_ce) begin
      if (in_win) begin
        rgb_d = win_color;
      end else if (active) begin
        rgb_d = BG_COLOR;
      end else begin
        rgb_d = 12'h000;
      end
      hs_d = !((hcnt_q >= H_SYNC_LO) && (hcnt_q <= H_SYNC_HI));
      vs_d = !((vcnt_q >= V_SYNC_LO) && (vcnt_q <= V_SYNC_HI));
      // Pulse is deliberately one clk wide, not held for the whole pixel
      fs_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 3'd0;
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
      rgb_q  <= 12'h000;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_gpu_scanout.sv
// tb_gpu_scanout: directed bench for gpu_scanout with CLK_DIV=4 and BG_COLOR=12'hABC.
// Latency: checks colour/syncs one pixel after the raster position, ROM signals in the same cycle.
// Backpressure: not applicable; the ROM model answers combinationally with addr[11:0].
module tb_gpu_scanout;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic        rom_rd_en;
  logic [11:0] rom_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;
  logic        frame_start;
  logic [11:0] rgb;
`ifdef GPU_SCANOUT_TESTPAT_EN
  logic        test_en = 1'b0;
`endif

  always #5 clk = ~clk;

  assign rom_data = rom_addr[11:0];
  assign rgb      = {vga_r, vga_g, vga_b};

  gpu_scanout #(
    .CLK_DIV (DIV),
    .IMG_X0  (192),
    .IMG_Y0  (112),
    .BG_COLOR(12'hABC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef GPU_SCANOUT_TESTPAT_EN
    .test_en    (test_en),
`endif
    .rom_addr   (rom_addr),
    .rom_rd_en  (rom_rd_en),
    .rom_data   (rom_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Raster jump: overwrite the counters, then let the design run on from there
  logic [9:0] jh, jv;
  task automatic jump(input logic [9:0] h, input logic [9:0] v);
    jh = h;
    jv = v;
    force dut.hcnt_q = jh;
    force dut.vcnt_q = jv;
    #1;
    release dut.hcnt_q;
    release dut.vcnt_q;
    #1;
  endtask

  // From a negedge with the divider at 0, advance exactly one pixel
  task automatic pix_step();
    repeat (DIV) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        rd;
    logic [15:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [9:0] h, input logic [9:0] v, input logic rd,
                     input logic [15:0] a, input logic [11:0] c, input logic hs, input logic vs);
    vec_t e;
    e.name = n; e.h = h; e.v = v; e.rd = rd; e.addr = a; e.rgb = c; e.hs = hs; e.vs = vs;
    vecs.push_back(e);
  endtask

  // Reset release: frame_start must appear exactly on the DIV-th clk, for one clk
  task automatic release_and_check_first_frame(input string tag);
    int fs_at;
    int fs_cnt;
    fs_at  = -1;
    fs_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 2 * DIV; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = k;
      end
    end
    chk({tag, "_fs_clk"}, 32'(fs_at), 32'(DIV));
    chk({tag, "_fs_cnt"}, 32'(fs_cnt), 32'd1);
    // pixel (0,0) is active but outside the image
    chk({tag, "_rgb00"}, 32'(rgb), 32'h0ABC);
  endtask

  initial begin
    int lo_cnt, fall1, fall2, fs_step, fs_cnt;
    logic prev;

    add("win_tl",   10'd192, 10'd112, 1'b1, 16'h0000, 12'h000, 1'b1, 1'b1);
    add("win_br",   10'd447, 10'd367, 1'b1, 16'hFFFF, 12'hFFF, 1'b1, 1'b1);
    add("win_mid",  10'd300, 10'd250, 1'b1, 16'h8A6C, 12'hA6C, 1'b1, 1'b1);
    add("win_bl",   10'd192, 10'd367, 1'b1, 16'hFF00, 12'hF00, 1'b1, 1'b1);
    add("win_tr",   10'd447, 10'd112, 1'b1, 16'h00FF, 12'h0FF, 1'b1, 1'b1);
    add("left191",  10'd191, 10'd200, 1'b0, 16'h0000, 12'hABC, 1'b1, 1'b1);
    add("right448", 10'd448, 10'd200, 1'b0, 16'h0000, 12'hABC, 1'b1, 1'b1);
    add("below368", 10'd192, 10'd368, 1'b0, 16'h0000, 12'hABC, 1'b1, 1'b1);
    add("h700",     10'd700, 10'd100, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b1);
    add("v500",     10'd320, 10'd500, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1);
    add("v490",     10'd100, 10'd490, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b0);
    add("hv_sync",  10'd656, 10'd491, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
    add("h751",     10'd751, 10'd10,  1'b0, 16'h0000, 12'h000, 1'b0, 1'b1);
    add("h752",     10'd752, 10'd10,  1'b0, 16'h0000, 12'h000, 1'b1, 1'b1);
    add("h655",     10'd655, 10'd10,  1'b0, 16'h0000, 12'h000, 1'b1, 1'b1);
    add("act_last", 10'd639, 10'd479, 1'b0, 16'h0000, 12'hABC, 1'b1, 1'b1);
    add("h640",     10'd640, 10'd479, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1);
    add("v492",     10'd10,  10'd492, 1'b0, 16'h0000, 12'h000, 1'b1, 1'b1);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hs", 32'(vga_hs), 32'h1);
    chk("rst_vs", 32'(vga_vs), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_rd", 32'(rom_rd_en), 32'h0);
    release_and_check_first_frame("por");
    // realign to a negedge with the divider at 0
    repeat (2 * DIV - DIV) @(negedge clk);

    // Vector table: ROM signals now, registered outputs one pixel later
    foreach (vecs[i]) begin
      jump(vecs[i].h, vecs[i].v);
      chk({vecs[i].name, "_rd"}, 32'(rom_rd_en), 32'(vecs[i].rd));
      chk({vecs[i].name, "_addr"}, 32'(rom_addr), 32'(vecs[i].addr));
      pix_step();
      chk({vecs[i].name, "_rgb"}, 32'(rgb), 32'(vecs[i].rgb));
      chk({vecs[i].name, "_hs"}, 32'(vga_hs), 32'(vecs[i].hs));
      chk({vecs[i].name, "_vs"}, 32'(vga_vs), 32'(vecs[i].vs));
    end

    // Outputs hold between strobes even when the counters move underneath
    jump(10'd300, 10'd250);
    pix_step();
    jump(10'd700, 10'd100);
    for (int k = 1; k < DIV; k++) begin
      @(negedge clk);
      chk("hold_rgb", 32'(rgb), 32'h0A6C);
    end
    @(negedge clk);
    chk("hold_after", 32'(rgb), 32'h0);

    // Horizontal sync: 96 low pixels per line, 800 pixels between falling edges
    jump(10'd650, 10'd10);
    lo_cnt = 0; fall1 = -1; fall2 = -1; prev = vga_hs;
    for (int s = 0; s < 1000; s++) begin
      pix_step();
      if (vga_hs === 1'b0) lo_cnt++;
      if (prev === 1'b1 && vga_hs === 1'b0) begin
        if (fall1 < 0) fall1 = cyc; else if (fall2 < 0) fall2 = cyc;
      end
      prev = vga_hs;
    end
    chk("hs_low_2lines", 32'(lo_cnt), 32'd192);
    chk("hs_period_clks", 32'(fall2 - fall1), 32'(800 * DIV));

    // Vertical sync: low for exactly lines 490 and 491
    jump(10'd0, 10'd488);
    lo_cnt = 0;
    for (int s = 0; s < 5 * 800; s++) begin
      pix_step();
      if (vga_vs === 1'b0) lo_cnt++;
    end
    chk("vs_low_pixels", 32'(lo_cnt), 32'd1600);

    // Frame wrap: one frame_start pulse when (0,0) is presented after line 524
    jump(10'd790, 10'd524);
    fs_step = -1; fs_cnt = 0;
    for (int s = 1; s <= 14; s++) begin
      for (int k = 1; k <= DIV; k++) begin
        @(negedge clk);
        if (frame_start === 1'b1) begin
          fs_cnt++;
          fs_step = s;
        end
      end
      if (s == 11) chk("wrap_rgb00", 32'(rgb), 32'h0ABC);
    end
    chk("wrap_fs_cnt", 32'(fs_cnt), 32'd1);
    chk("wrap_fs_step", 32'(fs_step), 32'd11);

    // Mid-frame reset while syncs are low
    jump(10'd700, 10'd491);
    pix_step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_hs", 32'(vga_hs), 32'h1);
    chk("rst2_vs", 32'(vga_vs), 32'h1);
    repeat (2) @(negedge clk);
    release_and_check_first_frame("rst2");
    repeat (DIV) @(negedge clk);

    // Mid-frame reset inside the image at (300,250)
    jump(10'd300, 10'd250);
    pix_step();
    chk("pre_rst_rgb", 32'(rgb), 32'h0A6C);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst3_rgb", 32'(rgb), 32'h0);
    chk("rst3_hs", 32'(vga_hs), 32'h1);
    chk("rst3_vs", 32'(vga_vs), 32'h1);
    chk("rst3_fs", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    release_and_check_first_frame("rst3");
    repeat (DIV) @(negedge clk);

`ifdef GPU_SCANOUT_TESTPAT_EN
    test_en = 1'b1;
    jump(10'h20C, 10'h130);
    chk("tp_out_rd", 32'(rom_rd_en), 32'h0);
    pix_step();
    chk("tp_out_rgb", 32'(rgb), 32'h0ABC);
    jump(10'd300, 10'd250);
    chk("tp_in_rd", 32'(rom_rd_en), 32'h0);
    chk("tp_in_addr", 32'(rom_addr), 32'h8A6C);
    pix_step();
    chk("tp_in_rgb", 32'(rgb), 32'h02FD);
    test_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_scanout.md
GPU_SCANOUT -- requirements
Module: gpu_scanout

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- CLK_DIV, 4, system clocks per pixel (valid range 1..8).
- IMG_X0, 192, image left column in the active area.
- IMG_Y0, 112, image top row in the active area.
- BG_COLOR, 12'h000, RGB444 colour for active pixels outside the image.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- rom_addr, out, 16, pixel ROM address {row[7:0], col[7:0]}.
- rom_rd_en, out, 1, pixel ROM read enable.
- rom_data, in, 12, RGB444 data returned combinationally, same cycle.
- vga_r / vga_g / vga_b, out, 4 each, colour outputs.
- vga_hs / vga_vs, out, 1 each, syncs, active low.
- frame_start, out, 1, one-clk pulse at the start of each frame.
REQ-003 Clocking and reset SHALL be one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-004 A divider SHALL count 0..CLK_DIV-1 and assert pix_ce for one clk when the count equals CLK_DIV-1; CLK_DIV=1 SHALL give pix_ce every clk.
REQ-005 On each pix_ce, hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL increment when hcnt wraps, counting 0..524 and wrapping to 0.
REQ-006 Horizontal timing SHALL be active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-007 Vertical timing SHALL be active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-008 The image window SHALL be hcnt in [IMG_X0, IMG_X0+255] and vcnt in [IMG_Y0, IMG_Y0+255], intersected with the active area.
REQ-009 rom_rd_en SHALL be combinational and equal to the window condition; no read SHALL be issued outside the window.
REQ-010 rom_addr SHALL be {(vcnt-IMG_Y0)[7:0], (hcnt-IMG_X0)[7:0]} inside the window and 16'h0000 outside it.
REQ-011 On pix_ce, the output stage SHALL register the colour from the current counters:
- rom_data inside the window;
- BG_COLOR when active but outside the window;
- 12'h000 when outside the active area.
REQ-012 vga_hs and vga_vs SHALL be registered on the same pix_ce edge as colour, so sync and colour share one pixel of latency from the counters.
REQ-013 frame_start SHALL pulse for exactly one clk on the pix_ce where hcnt=0 and vcnt=0 are presented.
REQ-014 Between pix_ce strobes, all outputs SHALL hold their values.
REQ-015 rom_data SHALL be sampled only on pix_ce cycles with the window condition true.

Reset
REQ-016 While rst_n=0, the following SHALL hold:
- divider, hcnt and vcnt = 0;
- vga_r/g/b = 0;
- vga_hs = 1 and vga_vs = 1;
- frame_start = 0.
REQ-017 Assertion of rst_n mid-line or mid-frame SHALL take effect immediately, with no partial output pulse.
REQ-018 After deassertion, the first pix_ce SHALL occur CLK_DIV clks later and SHALL start frame 0 at hcnt=0, vcnt=0.

Configuration
REQ-019 The macro GPU_SCANOUT_TESTPAT_EN SHALL control a test-pattern feature.
- When defined: add input test_en (1 bit). test_en=1 replaces the window colour with {hcnt[7:4], vcnt[7:4], hcnt[7:4]^vcnt[7:4]}. rom_rd_en is then forced to 0 and rom_addr is unchanged.
- When undefined: no test_en port; the window always shows rom_data.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CLK_DIV=4, run 2 frames -> frame_start period 4*800*525=1,680,000 clks; vga_hs low 96 pixels per line; vga_vs low for lines 490-491.
- ROM model returns addr[11:0] -> at hcnt=192, vcnt=112 rom_addr=16'h0000; at hcnt=447, vcnt=367 rom_addr=16'hFFFF; colour matches one pixel later.
- hcnt=191 and hcnt=448 on line 200 -> rom_rd_en=0; colour = BG_COLOR (set 12'hABC) one pixel later.
- hcnt=700 on line 100 and any pixel on line 500 -> rgb=12'h000; rom_rd_en=0.
- Reset asserted at hcnt=300, vcnt=250 -> immediate rgb=0, vga_hs=vga_vs=1; after release the first frame_start occurs on the first pix_ce.
- GPU_SCANOUT_TESTPAT_EN defined with test_en=1 -> rom_rd_en never 1; at hcnt=0x20C, vcnt=0x130, if inside the window, rgb={0,3,3}; if outside, BG_COLOR.
